mem_stage_sram: RTL and testbench
=================================

MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, meaning pipeline data width.
REQ-002 SHALL have parameter SRAM_ADDR_LEN, default 18, meaning external SRAM halfword-address width.
REQ-003 SHALL have parameter SRAM_WAIT, default 2, legal range 2..7, meaning cycles per SRAM halfword phase.
REQ-004 SHALL have parameter MEM_BASE, default 1024, meaning byte address mapped to SRAM halfword 0.
REQ-005 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports WB_EN_in, MEM_R_EN, MEM_W_EN  in  1 each  control from the EX/MEM register.
REQ-008 SHALL have port ALU_Res  in  DATA_LEN  byte address of the access.
REQ-009 SHALL have port Val_Rm  in  DATA_LEN  store data.
REQ-010 SHALL have port WB_EN_out  out  1  WB_EN_in AND ready, to the MEM/WB register.
REQ-011 SHALL have port MEM_OUT  out  DATA_LEN  registered load data.
REQ-012 SHALL have port ready  out  1  0 freezes all upstream pipeline registers.
REQ-013 SHALL have ports SRAM_ADDR  out  SRAM_ADDR_LEN;  SRAM_DQ_out  out  16;  SRAM_DQ_in  in  16;  SRAM_DQ_oe  out  1;  SRAM_WE_N, SRAM_OE_N  out  1 each.

Function
REQ-014 SHALL implement FSM states IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-015 IDLE: MEM_R_EN=1 -> RD_LO; else MEM_W_EN=1 -> WR_LO; else stay IDLE.
REQ-016 Both MEM_R_EN and MEM_W_EN set SHALL be handled as a read; the write is dropped.
REQ-017 Each of RD_LO, RD_HI, WR_LO and WR_HI SHALL last exactly SRAM_WAIT cycles, timed by a 3-bit counter that is cleared on phase entry.
REQ-018 Phase sequence SHALL be: RD_LO -> RD_HI -> DONE; WR_LO -> WR_HI -> DONE; DONE -> IDLE unconditionally.
REQ-019 The word address SHALL be word = (ALU_Res - MEM_BASE) >> 2, with ALU_Res[1:0] ignored.
REQ-020 SRAM_ADDR SHALL be {word,1'b0} in the LO states and {word,1'b1} in the HI states, truncated to SRAM_ADDR_LEN.
REQ-021 Read phases SHALL drive SRAM_OE_N=0 throughout; SRAM_DQ_in is captured on the last cycle of the phase.
REQ-022 RD_LO capture SHALL go to MEM_OUT[15:0]; RD_HI capture SHALL go to MEM_OUT[31:16].
REQ-023 Write phases SHALL drive SRAM_DQ_oe=1 for all cycles of the phase.
REQ-024 SRAM_DQ_out SHALL be Val_Rm[15:0] in WR_LO and Val_Rm[31:16] in WR_HI.
REQ-025 In write phases, SRAM_WE_N SHALL be 0 for the first SRAM_WAIT-1 cycles and 1 on the last cycle.
REQ-026 Outside their phases, SRAM_OE_N=1, SRAM_WE_N=1, SRAM_DQ_oe=0 and SRAM_ADDR=0.
REQ-027 ready SHALL be combinational: 0 when (MEM_R_EN|MEM_W_EN) and state != DONE, else 1.
REQ-028 Each access SHALL take 2*SRAM_WAIT+2 cycles, with ready=1 only in the final (DONE) cycle.
REQ-029 MEM_OUT SHALL hold its value between reads; writes SHALL not alter it.
REQ-030 Inputs SHALL be stable while ready=0, because upstream is frozen; the block does not latch them.

Reset
REQ-031 rst low SHALL immediately force state=IDLE, counter=0 and MEM_OUT=0.
REQ-032 rst low SHALL immediately force SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0 and SRAM_ADDR=0.
REQ-033 Reset asserted mid-access SHALL abort the access; the write may be partial, and there are no further SRAM strobes.

Structure
REQ-034 Shared package sram_pkg SHALL hold the state encoding, MEM_BASE, the SRAM widths and the default SRAM_WAIT.
REQ-035 The phase counter SHALL be one sub-module, sram_wait_counter, with inputs clear/enable and output last_cycle.

Verification
REQ-036 Read: preload SRAM halfwords 0=0xBEEF and 1=0xDEAD; ALU_Res=1024, MEM_R_EN=1 -> ready low 5 cycles, then MEM_OUT=0xDEADBEEF with ready=1 for 1 cycle.
REQ-037 Write: ALU_Res=1032, Val_Rm=0x12345678 -> halfword 4=0x5678 and halfword 5=0x1234; WE_N low 1 cycle per phase; MEM_OUT unchanged.
REQ-038 Simultaneous R/W: both enables set at ALU_Res=1024 -> read occurs, SRAM_WE_N never 0.
REQ-039 Back-to-back: a write then a read to the same address -> read returns the written word; WB_EN_out=0 while ready=0.
REQ-040 Reset mid-write: rst low during WR_HI -> outputs reach the REQ-031/REQ-032 values in the same cycle; after release, IDLE with ready=1 and no requests.
REQ-041 Idle: no enables -> ready=1, WB_EN_out follows WB_EN_in, SRAM_OE_N=1 and SRAM_WE_N=1.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the MEM stage external-SRAM interface:
// FSM encoding, memory map base, SRAM widths and default wait count.
package sram_pkg;
   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

   localparam int MEM_BASE_DEF  = 1024;
   localparam int SRAM_ADDR_W   = 18;
   localparam int SRAM_DQ_W     = 16;
   localparam int SRAM_WAIT_DEF = 2;
   localparam int CNT_W         = 3;
endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: counts cycles inside one SRAM halfword phase and flags the last one.
module sram_wait_counter
   import sram_pkg::*;
#(
   parameter int SRAM_WAIT = SRAM_WAIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic last_cycle
);
   logic [CNT_W-1:0] r_cnt;

   assign last_cycle = (r_cnt == CNT_W'(SRAM_WAIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     r_cnt <= '0;
      else if (clear)               r_cnt <= '0;
      else if (enable && !last_cycle) r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage backed by a 16-bit asynchronous SRAM: each 32-bit access is
// split into LO/HI halfword phases, and ready stalls upstream until DONE.
module mem_stage_sram
   import sram_pkg::*;
#(
   parameter int DATA_LEN      = 32,
   parameter int SRAM_ADDR_LEN = SRAM_ADDR_W,
   parameter int SRAM_WAIT     = SRAM_WAIT_DEF,
   parameter int MEM_BASE      = MEM_BASE_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     WB_EN_in,
   input  logic                     MEM_R_EN,
   input  logic                     MEM_W_EN,
   input  logic [DATA_LEN-1:0]      ALU_Res,
   input  logic [DATA_LEN-1:0]      Val_Rm,
   output logic                     WB_EN_out,
   output logic [DATA_LEN-1:0]      MEM_OUT,
   output logic                     ready,
   output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
   output logic [SRAM_DQ_W-1:0]     SRAM_DQ_out,
   input  logic [SRAM_DQ_W-1:0]     SRAM_DQ_in,
   output logic                     SRAM_DQ_oe,
   output logic                     SRAM_WE_N,
   output logic                     SRAM_OE_N
);
   state_t                   r_state, w_next;
   logic                     w_last, w_clear, w_phase, w_hi;
   logic [DATA_LEN-1:0]      w_off;
   logic [SRAM_ADDR_LEN-1:0] w_haddr;
   logic [DATA_LEN-1:0]      r_mem_out;
   logic                     w_unused;

   // Halfword address: word index shifted left, LSB selects the upper half.
   assign w_off    = ALU_Res - DATA_LEN'(MEM_BASE);
   assign w_hi     = (r_state == RD_HI) || (r_state == WR_HI);
   assign w_haddr  = {w_off[SRAM_ADDR_LEN:2], w_hi};
   assign w_unused = ^{w_off[DATA_LEN-1:SRAM_ADDR_LEN+1], w_off[1:0]};

   assign w_phase  = (r_state == RD_LO) || (r_state == RD_HI) ||
                     (r_state == WR_LO) || (r_state == WR_HI);
   assign w_clear  = (w_next != r_state);

   assign ready     = !((MEM_R_EN || MEM_W_EN) && (r_state != DONE));
   assign WB_EN_out = WB_EN_in && ready;
   assign MEM_OUT   = r_mem_out;

   sram_wait_counter #(.SRAM_WAIT(SRAM_WAIT)) u_wait (
      .clk       (clk),
      .rst       (rst),
      .clear     (w_clear),
      .enable    (w_phase),
      .last_cycle(w_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      SRAM_ADDR   = '0;
      SRAM_DQ_out = '0;
      SRAM_DQ_oe  = 1'b0;
      SRAM_WE_N   = 1'b1;
      SRAM_OE_N   = 1'b1;
      case (r_state)
         IDLE: begin
            // A simultaneous read and write is served as a read only.
            if (MEM_R_EN)      w_next = RD_LO;
            else if (MEM_W_EN) w_next = WR_LO;
         end
         RD_LO, RD_HI: begin
            SRAM_ADDR = w_haddr;
            SRAM_OE_N = 1'b0;
            if (w_last) w_next = (r_state == RD_LO) ? RD_HI : DONE;
         end
         WR_LO, WR_HI: begin
            SRAM_ADDR   = w_haddr;
            SRAM_DQ_oe  = 1'b1;
            SRAM_DQ_out = (r_state == WR_LO) ? Val_Rm[15:0] : Val_Rm[31:16];
            // WE_N rises on the last cycle so data/address hold past the strobe.
            SRAM_WE_N   = w_last;
            if (w_last) w_next = (r_state == WR_LO) ? WR_HI : DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           r_mem_out <= '0;
      else if (r_state == RD_LO && w_last) r_mem_out[15:0]  <= SRAM_DQ_in;
      else if (r_state == RD_HI && w_last) r_mem_out[31:16] <= SRAM_DQ_in;
   end
endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a behavioural 16-bit SRAM (SRAM_WAIT=2).
module tb_mem_stage_sram;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        WB_EN_in = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
   logic [31:0] ALU_Res = '0, Val_Rm = '0;
   logic        WB_EN_out, ready;
   logic [31:0] MEM_OUT;
   logic [17:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
   logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage_sram dut (
      .clk(clk), .rst(rst), .WB_EN_in(WB_EN_in), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .WB_EN_out(WB_EN_out), .MEM_OUT(MEM_OUT),
      .ready(ready), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
      .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
   );

   // SRAM model: combinational read, write sampled while WE_N is low.
   logic [15:0] sram [0:255];
   logic        poke = 1'b0;
   logic [7:0]  poke_a = '0;
   logic [15:0] poke_d = '0;
   int          we_low_total = 0;

   assign SRAM_DQ_in = SRAM_OE_N ? 16'h0000 : sram[SRAM_ADDR[7:0]];

   always @(posedge clk) begin
      if (poke) sram[poke_a] <= poke_d;
      else if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
      if (!SRAM_WE_N) we_low_total <= we_low_total + 1;
   end

   task automatic poke_hw(input logic [7:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      poke = 1'b1; poke_a = a; poke_d = d;
      @(posedge clk); #1;
      poke = 1'b0;
   endtask

   // Issues one request and returns at the negedge of the DONE cycle.
   task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int low, output int wbbad, output int we_low);
      int we0;
      @(posedge clk); #1;
      MEM_R_EN = r; MEM_W_EN = w; ALU_Res = a; Val_Rm = d; WB_EN_in = 1'b1;
      we0 = we_low_total;
      low = 0; wbbad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready) break;
         low++;
         if (WB_EN_out !== 1'b0) wbbad++;
      end
      we_low = we_low_total - we0;
   endtask

   task automatic release_req();
      @(posedge clk); #1;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN_in = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (MEM_OUT !== 32'h0) begin n_err++; $display("FAIL rst_mem_out got %h exp 0", MEM_OUT); end
      n_cmp++; if (SRAM_WE_N !== 1'b1) begin n_err++; $display("FAIL rst_we_n got %b exp 1", SRAM_WE_N); end
      n_cmp++; if (SRAM_OE_N !== 1'b1) begin n_err++; $display("FAIL rst_oe_n got %b exp 1", SRAM_OE_N); end
      n_cmp++; if (SRAM_DQ_oe !== 1'b0) begin n_err++; $display("FAIL rst_dq_oe got %b exp 0", SRAM_DQ_oe); end
      n_cmp++; if (SRAM_ADDR !== 18'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", SRAM_ADDR); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", ready); end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic test_read();
      int low, wbbad, we;
      poke_hw(8'd0, 16'hBEEF);
      poke_hw(8'd1, 16'hDEAD);
      access(1'b1, 1'b0, 32'd1024, 32'h0, low, wbbad, we);
      n_cmp++; if (low !== 5) begin n_err++; $display("FAIL read_stall got %0d exp 5", low); end
      n_cmp++; if (MEM_OUT !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_data got %h exp deadbeef", MEM_OUT); end
      n_cmp++; if (WB_EN_out !== 1'b1) begin n_err++; $display("FAIL read_wb_done got %b exp 1", WB_EN_out); end
      n_cmp++; if (wbbad !== 0) begin n_err++; $display("FAIL read_wb_stall got %0d exp 0", wbbad); end
      release_req();
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL read_after_ready got %b exp 1", ready); end
   endtask

   task automatic test_write();
      int low, wbbad, we;
      access(1'b0, 1'b1, 32'd1032, 32'h12345678, low, wbbad, we);
      n_cmp++; if (low !== 5) begin n_err++; $display("FAIL write_stall got %0d exp 5", low); end
      n_cmp++; if (we !== 2) begin n_err++; $display("FAIL write_we_cycles got %0d exp 2", we); end
      n_cmp++; if (sram[4] !== 16'h5678) begin n_err++; $display("FAIL write_hw4 got %h exp 5678", sram[4]); end
      n_cmp++; if (sram[5] !== 16'h1234) begin n_err++; $display("FAIL write_hw5 got %h exp 1234", sram[5]); end
      n_cmp++; if (MEM_OUT !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_mem_out got %h exp deadbeef", MEM_OUT); end
      release_req();
   endtask

   task automatic test_simultaneous();
      int low, wbbad, we;
      poke_hw(8'd0, 16'hA5A5);
      poke_hw(8'd1, 16'h5A5A);
      access(1'b1, 1'b1, 32'd1024, 32'h11112222, low, wbbad, we);
      n_cmp++; if (MEM_OUT !== 32'h5A5AA5A5) begin n_err++; $display("FAIL rw_data got %h exp 5a5aa5a5", MEM_OUT); end
      n_cmp++; if (we !== 0) begin n_err++; $display("FAIL rw_we_cycles got %0d exp 0", we); end
      n_cmp++; if (sram[0] !== 16'hA5A5) begin n_err++; $display("FAIL rw_hw0 got %h exp a5a5", sram[0]); end
      n_cmp++; if (low !== 5) begin n_err++; $display("FAIL rw_stall got %0d exp 5", low); end
      release_req();
   endtask

   task automatic test_back_to_back();
      int low1, low2, wb1, wb2, we1, we2;
      access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, low1, wb1, we1);
      access(1'b1, 1'b0, 32'd1040, 32'h0, low2, wb2, we2);
      n_cmp++; if (MEM_OUT !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_data got %h exp cafef00d", MEM_OUT); end
      n_cmp++; if (low1 + low2 !== 10) begin n_err++; $display("FAIL b2b_stall got %0d exp 10", low1 + low2); end
      n_cmp++; if (wb1 + wb2 !== 0) begin n_err++; $display("FAIL b2b_wb_stall got %0d exp 0", wb1 + wb2); end
      n_cmp++; if (sram[9] !== 16'hCAFE) begin n_err++; $display("FAIL b2b_hw9 got %h exp cafe", sram[9]); end
      release_req();
   endtask

   task automatic test_reset_mid_write();
      int we0;
      @(posedge clk); #1;
      MEM_W_EN = 1'b1; ALU_Res = 32'd1048; Val_Rm = 32'h0BADF00D; WB_EN_in = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      n_cmp++; if (SRAM_ADDR !== 18'd13) begin n_err++; $display("FAIL mid_addr got %0d exp 13", SRAM_ADDR); end
      n_cmp++; if (SRAM_WE_N !== 1'b0) begin n_err++; $display("FAIL mid_we_n got %b exp 0", SRAM_WE_N); end
      rst = 1'b0;
      #1;
      n_cmp++; if (SRAM_WE_N !== 1'b1) begin n_err++; $display("FAIL mid_rst_we_n got %b exp 1", SRAM_WE_N); end
      n_cmp++; if (SRAM_DQ_oe !== 1'b0) begin n_err++; $display("FAIL mid_rst_dq_oe got %b exp 0", SRAM_DQ_oe); end
      n_cmp++; if (SRAM_ADDR !== 18'h0) begin n_err++; $display("FAIL mid_rst_addr got %h exp 0", SRAM_ADDR); end
      n_cmp++; if (SRAM_OE_N !== 1'b1) begin n_err++; $display("FAIL mid_rst_oe_n got %b exp 1", SRAM_OE_N); end
      n_cmp++; if (MEM_OUT !== 32'h0) begin n_err++; $display("FAIL mid_rst_mem_out got %h exp 0", MEM_OUT); end
      n_cmp++; if (sram[12] !== 16'hF00D) begin n_err++; $display("FAIL mid_hw12 got %h exp f00d", sram[12]); end
      MEM_W_EN = 1'b0; WB_EN_in = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      we0 = we_low_total;
      repeat (4) @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_post_ready got %b exp 1", ready); end
      n_cmp++; if (we_low_total - we0 !== 0) begin n_err++; $display("FAIL mid_post_we got %0d exp 0", we_low_total - we0); end
   endtask

   task automatic test_idle();
      @(posedge clk); #1 WB_EN_in = 1'b1;
      @(negedge clk);
      n_cmp++; if (WB_EN_out !== 1'b1) begin n_err++; $display("FAIL idle_wb1 got %b exp 1", WB_EN_out); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL idle_ready got %b exp 1", ready); end
      n_cmp++; if (SRAM_OE_N !== 1'b1) begin n_err++; $display("FAIL idle_oe_n got %b exp 1", SRAM_OE_N); end
      n_cmp++; if (SRAM_WE_N !== 1'b1) begin n_err++; $display("FAIL idle_we_n got %b exp 1", SRAM_WE_N); end
      @(posedge clk); #1 WB_EN_in = 1'b0;
      @(negedge clk);
      n_cmp++; if (WB_EN_out !== 1'b0) begin n_err++; $display("FAIL idle_wb0 got %b exp 0", WB_EN_out); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_write();
      test_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
